// File: rtl/seq_ctrl_pkg.sv
// Shared types and default parameters for the sequence controller slice.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          DEF_DATA_W  = 8;
  localparam int          DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;

  // Width of a counter that must hold every value from 0 up to max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// Bit-serial pattern matcher: sliding history, fill tracking and per-run hit count.
module seq_pattern_matcher
  import seq_ctrl_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        bit_valid_i,
  input  logic                        bit_i,
  output logic                        hit_o,
  output logic [cnt_w(DATA_W)-1:0]    run_cnt_o
);

  localparam int                CNT_W     = cnt_w(DATA_W);
  localparam int                FILL_W    = cnt_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PREV = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_next;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;

  // A one-bit pattern has no older history to shift along.
  generate
    if (PAT_W == 1) begin : g_single
      assign hist_next = bit_i;
    end else begin : g_multi
      assign hist_next = {hist_q[PAT_W-2:0], bit_i};
    end
  endgenerate

  // Compare the window including the incoming bit; update history, fill and run count.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hist_d    = hist_q;
    fill_d    = fill_q;
    run_cnt_d = run_cnt_q;
    // The fill count is taken before this bit, so PAT_W-1 earlier bits plus this one is a full window.
    hit_o     = bit_valid_i && (fill_q >= FILL_PREV) && (hist_next == PATTERN);
    if (clr_i) begin
      hist_d    = '0;
      fill_d    = '0;
      run_cnt_d = '0;
    end else if (bit_valid_i) begin
      hist_d = hist_next;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
      if (hit_o) begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
      end
    end
  end

  // Matcher state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      run_cnt_q <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign run_cnt_o = run_cnt_q;

endmodule

// File: rtl/sequence_ctrl.sv
// Button-triggered controller: loads the switch byte, streams it MSB-first
// through the matcher and latches the hit count and LED verdict.
module sequence_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button,
  input  logic [DATA_W-1:0]         switch,
  output logic                      led,
  output logic [cnt_w(DATA_W)-1:0]  match_cnt,
  output logic                      busy,
  output logic                      done
);

  localparam int               CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic                btn_q;
  logic                start;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                led_q;
  logic [CNT_W-1:0]    match_cnt_q;
  logic                m_clr, m_bit_valid, m_hit, result_load;
  logic [CNT_W-1:0]    m_run_cnt, run_total;

  // Only a rising edge on the button requests a run.
  assign start = button & ~btn_q;

  seq_pattern_matcher #(
    .DATA_W  (DATA_W),
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (m_clr),
    .bit_valid_i (m_bit_valid),
    .bit_i       (sreg_q[DATA_W-1]),
    .hit_o       (m_hit),
    .run_cnt_o   (m_run_cnt)
  );

  // The last bit's hit is not yet in the matcher's counter when the result is latched.
  assign run_total = m_run_cnt + CNT_W'(m_hit);

  // Next-state, shift-register and matcher-control decode.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    m_clr       = 1'b0;
    m_bit_valid = 1'b0;
    result_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        sreg_d    = switch;
        bit_cnt_d = '0;
        m_clr     = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        m_bit_valid = 1'b1;
        sreg_d      = sreg_q << 1;
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          result_load = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      btn_q       <= 1'b1;  // a button held through reset must not look like a fresh press
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      led_q       <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      btn_q     <= button;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      if (result_load) begin
        match_cnt_q <= run_total;
        led_q       <= (run_total != '0);
      end
    end
  end

  assign led       = led_q;
  assign match_cnt = match_cnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/sequence_ctrl.md
# sequence_ctrl

Controller that serializes a switch-loaded byte into a bit-serial pattern matcher and reports the result on the board LED. It sits between the debounced push-button/switch inputs and the sequence-detection datapath. On each button press it captures `switch`, streams it MSB-first through the matcher, counts overlapping pattern hits, and registers the verdict. Presses that arrive while a byte is in flight are ignored.

## Interface
- `DATA_W`, default 8: switch byte width, which is also the bits per run.
- `PAT_W`, default 4: detected pattern length; must satisfy 1 ≤ PAT_W ≤ DATA_W.
- `PATTERN`, default 4'b1011: pattern to detect; MSB is the first bit in time.
- `clk` in, 1: system clock, all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `button` in, 1: start request (already debounced), level input; only the rising edge is used.
- `switch` in, DATA_W: byte to scan; sampled in LOAD only.
- `led` out, 1: 1 when the last completed run had ≥1 match.
- `match_cnt` out, $clog2(DATA_W+1): number of matches in the last completed run.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse marking the run end.

## Operation
- Edge detect:
  - `btn_q` registers `button`.
  - `start = button & ~btn_q`.
- FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE → LOAD on `start`. Otherwise stay.
  - LOAD:
    - `sreg ← switch`, `bit_cnt ← 0`.
    - Matcher history, its fill counter and the run counter are cleared.
    - → SHIFT.
  - SHIFT, once per cycle:
    - Bit `sreg[DATA_W-1]` goes to the matcher.
    - `sreg ← sreg << 1` and `bit_cnt++`.
    - On the DATA_W-th bit (`bit_cnt == DATA_W-1`) → DONE.
  - DONE → IDLE unconditionally.
- Matcher:
  - `hist_next = {hist[PAT_W-2:0], bit}`.
  - Hit when `hist_next == PATTERN` and at least PAT_W bits have been shifted in this run, including the current bit.
  - Overlapping matches count.
  - History never carries across runs.
- Result register:
  - Loaded on the clock edge that enters DONE.
  - `match_cnt ← run count` including a hit on the final bit; `led ← (run count != 0)`.
  - Both hold until the next run completes.
- `start` seen in LOAD, SHIFT or DONE is discarded, not queued.
- A held button gives only one run.
- The `switch` value is taken only at LOAD; changes during SHIFT have no effect.
- Reset values:
  - State IDLE, `sreg` 0, `bit_cnt` 0, history and counters 0.
  - `led` 0, `match_cnt` 0, `busy` 0, `done` 0.
  - `btn_q` resets to 1, so a button already held high through reset does not start a run.
- Reset mid-run aborts immediately. Outputs return to their reset values and no `done` pulse is produced.

## Timing
- Cycle 0 is the clock edge that samples `start`; after it the state is LOAD.
- Edge 1: `sreg` is loaded and the state becomes SHIFT. `busy` is high from edge 0.
- Edges 2..DATA_W+1 (2..9 by default): one bit processed per edge.
- Edge DATA_W+1 (9):
  - `led` and `match_cnt` update.
  - State becomes DONE and `done` goes high for exactly one cycle.
- Edge DATA_W+2 (10): state is IDLE and `busy` drops.
  - A new `start` is accepted from this edge on.
  - The earliest back-to-back run begins at edge 10, which needs a button release and re-press.
- Total turnaround is DATA_W+2 cycles from the start edge to the return to IDLE.

## Structure
- Package `seq_ctrl_pkg` holds:
  - the `state_t` enum (IDLE, LOAD, SHIFT, DONE);
  - the default constants DATA_W=8, PAT_W=4, PATTERN=4'b1011;
  - the function computing the `match_cnt` width.
- Sub-module `seq_pattern_matcher` covers:
  - inputs `clr`, `bit_valid` and `bit`;
  - the PAT_W history register and its fill counter;
  - the comparator;
  - the `hit` output and the saturating-free run counter.
- The top-level module `sequence_ctrl` keeps the FSM, edge detect, shift register and result registers.

## Test plan
- Hits on the final bit:
  - Stimulus: `switch` = 8'b01101011, button pulse of 10 ns.
  - Required: `done` pulse at start edge + 9, `match_cnt` = 1, `led` = 1.
- No hits:
  - Stimulus: `switch` = 8'b11001100, press.
  - Required: `match_cnt` = 0 and `led` = 0, with the previous result overwritten at the DONE edge.
- Overlapping hits:
  - Stimulus: `switch` = 8'b10110110.
  - Required: `match_cnt` = 2.
  - Stimulus: `switch` = 8'b10111011.
  - Required: `match_cnt` = 2.
- Ignored inputs during a run:
  - Stimulus: press, change `switch` and press again during SHIFT; `switch` is 8'b00110100 at LOAD.
  - Required: exactly one `done` pulse, and `match_cnt` = 0, which is the result for the LOAD value.
  - Stimulus: button held high for 30 cycles.
  - Required: exactly one run.
- Reset behaviour:
  - Stimulus: assert `rst` one cycle mid-SHIFT.
  - Required: next edge shows `busy` 0, `led` 0, `match_cnt` 0, and no `done` pulse.
  - Stimulus: `button` held high through reset release.
  - Required: no run starts.
- Parameter sweep:
  - Stimulus: PATTERN = 4'b0000 with `switch` = 8'h00.
  - Required: `match_cnt` = 5 (maximum overlap), and history is not carried into a following 8'hFF run, which gives `match_cnt` = 0.
